multnxm_fast: RTL and testbench

Parametrised sequential multiplier, the successor of the fixed 32x32 fast multiplier. It forms an A_W x B_W product by accumulating partial products from one CHUNK_A x CHUNK_B combinational multiplier. It skips every partial product whose operand chunk is zero. It adds a per-operation signed mode and a completion pulse, and sits in the same datapath slot as the 32x32 block, using the same start/busy handshake.

---
 rtl/multnxm_pkg.sv | 19 +
 rtl/multnxm_fast_if.sv | 27 ++
 rtl/multnxm_fast_chunk.sv | 15 +
 rtl/multnxm_fast.sv | 188 ++++++++++++++++++
 tb/tb_multnxm_fast.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/multnxm_pkg.sv
// Shared types and defaults for the chunked sequential multiplier.
package multnxm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NEG
  } state_t;

  localparam int unsigned DEF_A_W     = 32;
  localparam int unsigned DEF_B_W     = 32;
  localparam int unsigned DEF_CHUNK_A = 8;
  localparam int unsigned DEF_CHUNK_B = 16;

  function automatic int unsigned chunk_count(input int unsigned w, input int unsigned c);
    return w / c;
  endfunction

endpackage

// File: rtl/multnxm_fast_if.sv
// Start/busy handshake and operand/result bus of multnxm_fast.
interface multnxm_fast_if
  import multnxm_pkg::*;
#(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W
) ();

  logic                 start;
  logic                 signed_mode;
  logic [A_W-1:0]       a;
  logic [B_W-1:0]       b;
  logic                 busy;
  logic                 done;
  logic [A_W+B_W-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/multnxm_fast_chunk.sv
// Combinational unsigned CHUNK_A x CHUNK_B multiplier; one instance serves every partial product.
module mult_chunk #(
  parameter int unsigned CHUNK_A = 8,
  parameter int unsigned CHUNK_B = 16
) (
  input  logic [CHUNK_A-1:0]         i_a,
  input  logic [CHUNK_B-1:0]         i_b,
  output logic [CHUNK_A+CHUNK_B-1:0] o_p
);

  localparam int unsigned P_W = CHUNK_A + CHUNK_B;

  assign o_p = P_W'(i_a) * P_W'(i_b);

endmodule

// File: rtl/multnxm_fast.sv
// Sequential A_W x B_W multiplier: accumulates nonzero chunk-pair partial products,
// then optionally negates for signed operands of opposite sign.
module multnxm_fast
  import multnxm_pkg::*;
#(
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned CHUNK_A = DEF_CHUNK_A,
  parameter int unsigned CHUNK_B = DEF_CHUNK_B
) (
  input  logic          clk,
  input  logic          reset,
  multnxm_fast_if.slave bus
);

  localparam int unsigned NA  = chunk_count(A_W, CHUNK_A);
  localparam int unsigned NB  = chunk_count(B_W, CHUNK_B);
  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned C_W = CHUNK_A + CHUNK_B;

  generate
    if ((A_W % CHUNK_A) != 0 || (B_W % CHUNK_B) != 0) begin : g_width_err
      $error("multnxm_fast: A_W and B_W must be multiples of CHUNK_A and CHUNK_B");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [A_W-1:0]   r_a_mag;
  logic [B_W-1:0]   r_b_mag;
  logic [NA-1:0]    r_mask_a;
  logic [NB-1:0]    r_mask_b;
  logic [NA-1:0]    r_pend_a;
  logic [NB-1:0]    r_pend_b;
  logic [P_W-1:0]   r_product;
  logic             r_done;

  logic             w_sign_a_in;
  logic             w_sign_b_in;
  logic [A_W-1:0]   w_a_mag_in;
  logic [B_W-1:0]   w_b_mag_in;
  logic [NA-1:0]    w_mask_a_in;
  logic [NB-1:0]    w_mask_b_in;

  logic [NA-1:0]    w_low_a;
  logic [NB-1:0]    w_low_b;
  logic [NA-1:0]    w_pend_a_nxt;
  logic [NB-1:0]    w_pend_b_nxt;
  logic [CHUNK_A-1:0] w_chunk_a;
  logic [CHUNK_B-1:0] w_chunk_b;
  logic [31:0]      w_sh_a;
  logic [31:0]      w_sh_b;
  logic [C_W-1:0]   w_pp;
  logic [P_W-1:0]   w_pp_sh;
  logic             w_k_zero;
  logic             w_mul_last;
  logic             w_negate;

  // Operand magnitudes and nonzero-chunk masks, captured on an accepted start.
  always_comb begin
    w_sign_a_in = bus.signed_mode & bus.a[A_W-1];
    w_sign_b_in = bus.signed_mode & bus.b[B_W-1];
    w_a_mag_in  = w_sign_a_in ? -bus.a : bus.a;
    w_b_mag_in  = w_sign_b_in ? -bus.b : bus.b;
    w_mask_a_in = '0;
    w_mask_b_in = '0;
    for (int unsigned k = 0; k < NA; k++) begin
      w_mask_a_in[k] = |w_a_mag_in[k*CHUNK_A +: CHUNK_A];
    end
    for (int unsigned k = 0; k < NB; k++) begin
      w_mask_b_in[k] = |w_b_mag_in[k*CHUNK_B +: CHUNK_B];
    end
  end

  // r_pend_a holds the a-chunks still to visit for the current b-chunk (lowest set
  // bit of r_pend_b); it is reloaded from r_mask_a whenever that b-chunk is exhausted.
  always_comb begin
    w_low_a      = r_pend_a & (-r_pend_a);
    w_low_b      = r_pend_b & (-r_pend_b);
    w_pend_a_nxt = r_pend_a & ~w_low_a;
    w_pend_b_nxt = r_pend_b & ~w_low_b;
    w_chunk_a    = '0;
    w_chunk_b    = '0;
    w_sh_a       = '0;
    w_sh_b       = '0;
    for (int unsigned k = 0; k < NA; k++) begin
      if (w_low_a[k]) begin
        w_chunk_a = r_a_mag[k*CHUNK_A +: CHUNK_A];
        w_sh_a    = k * CHUNK_A;
      end
    end
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_low_b[k]) begin
        w_chunk_b = r_b_mag[k*CHUNK_B +: CHUNK_B];
        w_sh_b    = k * CHUNK_B;
      end
    end
  end

  mult_chunk #(
    .CHUNK_A (CHUNK_A),
    .CHUNK_B (CHUNK_B)
  ) u_mult_chunk (
    .i_a (w_chunk_a),
    .i_b (w_chunk_b),
    .o_p (w_pp)
  );

  assign w_pp_sh    = P_W'(w_pp) << (w_sh_a + w_sh_b);
  assign w_k_zero   = ~(|r_pend_a) | ~(|r_pend_b);
  assign w_mul_last = w_k_zero | ((w_pend_a_nxt == '0) & (w_pend_b_nxt == '0));
  assign w_negate   = r_mode & (r_sign_a ^ r_sign_b) & (|r_mask_a) & (|r_mask_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = MUL;
      MUL:     if (w_mul_last) w_state_nxt = w_negate ? NEG : IDLE;
      NEG:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_mask_a  <= '0;
      r_mask_b  <= '0;
      r_pend_a  <= '0;
      r_pend_b  <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state != IDLE) && (w_state_nxt == IDLE);
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode    <= bus.signed_mode;
            r_sign_a  <= w_sign_a_in;
            r_sign_b  <= w_sign_b_in;
            r_a_mag   <= w_a_mag_in;
            r_b_mag   <= w_b_mag_in;
            r_mask_a  <= w_mask_a_in;
            r_mask_b  <= w_mask_b_in;
            r_pend_a  <= w_mask_a_in;
            r_pend_b  <= w_mask_b_in;
            r_product <= '0;
          end
        end
        MUL: begin
          if (!w_k_zero) begin
            r_product <= r_product + w_pp_sh;
            if (w_pend_a_nxt == '0) begin
              r_pend_a <= r_mask_a;
              r_pend_b <= w_pend_b_nxt;
            end else begin
              r_pend_a <= w_pend_a_nxt;
            end
          end
        end
        NEG: begin
          r_product <= -r_product;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_multnxm_fast.sv
// Directed and swept-parameter checks of multnxm_fast against behavioural reference products.
module tb_multnxm_fast;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  multnxm_fast_if #(.A_W(32), .B_W(32)) bus  ();
  multnxm_fast_if #(.A_W(16), .B_W(24)) bus2 ();

  multnxm_fast u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  multnxm_fast #(
    .A_W     (16),
    .B_W     (24),
    .CHUNK_A (4),
    .CHUNK_B (8)
  ) u_sw (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge with the DUT idle; scrambles inputs while busy to prove latching.
  task automatic op_def(input string tag, input logic sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_p,
                        input int unsigned exp_busy, input logic poke);
    int unsigned cnt = 0;
    bus.start = 1'b1; bus.signed_mode = sm; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.signed_mode = ~sm;
    while (bus.busy && cnt < 40) begin
      cnt++;
      bus.start = poke && (cnt == 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, ".busy_len"}, 64'(cnt), 64'(exp_busy));
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".product"}, bus.product, exp_p);
    @(negedge clk);
    chk({tag, ".done_once"}, 64'(bus.done), 64'd0);
  endtask

  task automatic op_sw(input int n, input logic sm, input logic [15:0] a, input logic [23:0] b);
    logic [15:0] am;
    logic [23:0] bm;
    logic [39:0] ax, bx, exp_p;
    int unsigned ka = 0, kb = 0, k, exp_busy, cnt = 0;
    logic neg;
    am = (sm && a[15]) ? 16'(-a) : a;
    bm = (sm && b[23]) ? 24'(-b) : b;
    for (int i = 0; i < 4; i++) if (am[i*4 +: 4] != 4'h0) ka++;
    for (int j = 0; j < 3; j++) if (bm[j*8 +: 8] != 8'h00) kb++;
    k = ka * kb;
    neg = sm && (a[15] ^ b[23]) && (k > 0);
    exp_busy = ((k == 0) ? 1 : k) + (neg ? 1 : 0);
    ax = sm ? {{24{a[15]}}, a} : {24'h0, a};
    bx = sm ? {{16{b[23]}}, b} : {16'h0, b};
    exp_p = ax * bx;
    bus2.start = 1'b1; bus2.signed_mode = sm; bus2.a = a; bus2.b = b;
    @(negedge clk);
    bus2.start = 1'b0; bus2.a = 16'($urandom); bus2.b = 24'($urandom);
    while (bus2.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("sweep%0d.busy_len", n), 64'(cnt), 64'(exp_busy));
    chk($sformatf("sweep%0d.product", n), 64'(bus2.product), 64'(exp_p));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    bus2.start = 1'b0; bus2.signed_mode = 1'b0; bus2.a = '0; bus2.b = '0;
    #12;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.no_done", 64'(bus.done), 64'd0);

    op_def("u_full", 1'b0, 32'h12B06F63, 32'h0C5A1923, 64'd313552739 * 64'd207231267, 8, 1'b0);
    op_def("u_low",  1'b0, 32'h00006F63, 32'h00001923, 64'd183494025, 2, 1'b0);
    op_def("zero",   1'b0, 32'h00000000, 32'hFFFFFFFF, 64'd0, 1, 1'b0);
    op_def("k1",     1'b0, 32'h00FF0000, 32'h00010000, 64'h000000FF00000000, 1, 1'b0);
    op_def("s_neg",  1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 2, 1'b0);
    op_def("s_min",  1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1, 1'b0);
    op_def("poke",   1'b0, 32'h12B06F63, 32'h0C5A1923, 64'd313552739 * 64'd207231267, 8, 1'b1);

    // start held high across the done cycle: second operation accepted back-to-back
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 32'h00006F63; bus.b = 32'h00001923;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("b2b.first_done", 64'(bus.done), 64'd1);
    chk("b2b.first_product", bus.product, 64'd183494025);
    bus.a = 32'h00FF0000; bus.b = 32'h00010000;
    @(negedge clk);
    chk("b2b.accepted", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b.second_idle", 64'(bus.busy), 64'd0);
    chk("b2b.second_done", 64'(bus.done), 64'd1);
    chk("b2b.second_product", bus.product, 64'h000000FF00000000);
    @(negedge clk);

    // reset asserted mid-MUL
    bus.start = 1'b1; bus.a = 32'h12B06F63; bus.b = 32'h0C5A1923;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.was_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.done", 64'(bus.done), 64'd0);
    chk("midrst.product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.no_done", 64'(bus.done), 64'd0);
    op_def("post_rst", 1'b1, 32'hFFFFFFF9, 32'h00000006, 64'hFFFFFFFFFFFFFFD6, 2, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra;
      logic [23:0] rb;
      ra = 16'($urandom);
      rb = 24'($urandom);
      for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) ra[i*4 +: 4] = 4'h0;
      for (int j = 0; j < 3; j++) if ($urandom_range(3) == 0) rb[j*8 +: 8] = 8'h00;
      op_sw(n, 1'($urandom_range(1)), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
